// File: rtl/capture_ramblk_ctrl.sv
// Snapshot capture buffer: one selected lane written into a dual-port RAM until a trigger completes.
// Latency: capture writes on the edge ending the input cycle; read data and valid appear 2 cycles after rd_en.
// Backpressure: none; din_valid is accepted every cycle, and reads are accepted every cycle with no stall.
module capture_ramblk_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int NCHAN  = 4,
    parameter int CSEL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCHAN*DWIDTH-1:0] din,
    input  logic                    din_valid,
    input  logic                    arm,
    input  logic                    trig,
    input  logic                    mode,
    input  logic [CSEL_W-1:0]       chan_sel,
    input  logic [AWIDTH:0]         post_count,
    output logic                    busy,
    output logic                    done,
    output logic                    wrapped,
    output logic [AWIDTH-1:0]       stop_addr,
    input  logic                    rd_en,
    input  logic [AWIDTH-1:0]       rd_addr,
    output logic [DWIDTH-1:0]       rd_data,
    output logic                    rd_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [AWIDTH:0]   DEPTH_L  = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   REM_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CSEL_W:0]   NCHAN_L  = NCHAN[CSEL_W:0];

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic                wrapped_q, wrapped_d;
    logic [AWIDTH:0]     rem_q, rem_d;
    logic                mode_q, mode_d;
    logic [CSEL_W-1:0]   chan_q, chan_d;
    logic [AWIDTH-1:0]   stop_addr_q, stop_addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DWIDTH-1:0]   rd_data_q, rd_data_d;

    logic                wr_en;
    logic                rem_dec;
    logic [DWIDTH-1:0]   wr_dat;
    logic [DWIDTH-1:0]   ram_rd_q;
    logic [DWIDTH-1:0]   mem [0:(1<<AWIDTH)-1];

    assign wr_dat = din[int'(chan_q)*DWIDTH +: DWIDTH];

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wrapped_d   = wrapped_q;
        rem_d       = rem_q;
        mode_d      = mode_q;
        chan_d      = chan_q;
        stop_addr_d = stop_addr_q;
        wr_en       = 1'b0;
        rem_dec     = 1'b0;

        if (arm) begin
            // arm restarts from any state and masks a coincident trigger
            state_d   = S_ARMED;
            wr_addr_d = '0;
            wrapped_d = 1'b0;
            mode_d    = mode;
            chan_d    = ({1'b0, chan_sel} >= NCHAN_L) ? '0 : chan_sel;
            rem_d     = (post_count > DEPTH_L) ? DEPTH_L : post_count;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trig) begin
                        if (rem_q == '0) begin
                            state_d     = S_DONE;
                            stop_addr_d = wr_addr_q;
                        end else begin
                            state_d = S_POST;
                            wr_en   = din_valid;
                            rem_dec = din_valid;
                        end
                    end else begin
                        wr_en = mode_q & din_valid;
                    end
                end
                S_POST: begin
                    wr_en   = din_valid;
                    rem_dec = din_valid;
                end
                default: ;
            endcase
        end

        if (wr_en) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (&wr_addr_q) begin
                wrapped_d = 1'b1;
            end
        end

        // the write that consumes the last remaining slot freezes the RAM
        if (rem_dec) begin
            rem_d = rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
                state_d     = S_DONE;
                stop_addr_d = wr_addr_d;
            end
        end
    end

    always_comb begin
        rd_pend_d  = rd_en;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? ram_rd_q : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            wrapped_q   <= 1'b0;
            rem_q       <= '0;
            mode_q      <= 1'b0;
            chan_q      <= '0;
            stop_addr_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            wrapped_q   <= wrapped_d;
            rem_q       <= rem_d;
            mode_q      <= mode_d;
            chan_q      <= chan_d;
            stop_addr_q <= stop_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // RAM array and its output register are not reset; nonblocking update gives read-first
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= wr_dat;
        end
        if (rd_en) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    assign busy      = (state_q == S_ARMED) || (state_q == S_POST);
    assign done      = (state_q == S_DONE);
    assign wrapped   = wrapped_q;
    assign stop_addr = stop_addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_capture_ramblk_ctrl.sv
// Directed bench for capture_ramblk_ctrl: status checked inline, read data checked by a queue-driven monitor.
module tb_capture_ramblk_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NC = 4;
    localparam int CW = 2;

    logic               clk;
    logic               rst_n;
    logic [NC*DW-1:0]   din;
    logic               din_valid;
    logic               arm;
    logic               trig;
    logic               mode;
    logic [CW-1:0]      chan_sel;
    logic [AW:0]        post_count;
    logic               busy;
    logic               done;
    logic               wrapped;
    logic [AW-1:0]      stop_addr;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;
    logic               rd_valid;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    logic [31:0] exp_dat_q [$];
    int          exp_cyc_q [$];

    capture_ramblk_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .NCHAN(NC), .CSEL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .arm(arm), .trig(trig), .mode(mode), .chan_sel(chan_sel),
        .post_count(post_count), .busy(busy), .done(done), .wrapped(wrapped),
        .stop_addr(stop_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // selected lane carries v; other lanes carry markers that must never land in RAM
    task automatic drive(input int sel, input logic [31:0] v);
        for (int k = 0; k < NC; k++) begin
            din[k*DW +: DW] = (k == sel) ? v : (32'hDEAD_0000 + 32'(k));
        end
    endtask

    task automatic do_arm(input logic m, input int sel, input int pc);
        arm        = 1'b1;
        mode       = m;
        chan_sel   = CW'(sel);
        post_count = (AW+1)'(pc);
        cyc();
        arm = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] e);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        exp_dat_q.push_back(e);
        exp_cyc_q.push_back(cyc_cnt + 2);
    endtask

    // monitor: every rd_valid must match the oldest expected read, data and arrival cycle
    initial begin
        logic [31:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                total++;
                if (exp_dat_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected: got data 0x%h with no read pending", rd_data);
                end else begin
                    e = exp_dat_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    if (rd_data !== e || cyc_cnt != c) begin
                        bad++;
                        $display("FAIL rd_data: got %0d at cycle %0d want %0d at cycle %0d",
                                 rd_data, cyc_cnt, e, c);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; arm = 1'b0; trig = 1'b0;
        mode = 1'b0; chan_sel = '0; post_count = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wrapped", 32'(wrapped), 0);
        chk("rst_stop_addr", 32'(stop_addr), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        cyc();

        // reset in the middle of POST after a wrap
        din_valid = 1'b1;
        drive(0, 0);
        do_arm(1'b1, 0, 8);
        for (int i = 0; i < 17; i++) begin
            drive(0, 32'(i));
            cyc();
        end
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        cyc();
        chk("midpost_busy", 32'(busy), 1);
        chk("midpost_wrapped", 32'(wrapped), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_wrapped", 32'(wrapped), 0);
        cyc();
        rst_n = 1'b1;
        trig = 1'b1;
        repeat (3) cyc();
        trig = 1'b0;
        chk("idle_trig_busy", 32'(busy), 0);
        chk("idle_trig_done", 32'(done), 0);

        // one-shot, lane 2, five samples 100..104 from the trigger cycle
        din_valid = 1'b1;
        drive(2, 99);
        do_arm(1'b0, 2, 5);
        chk("m0_busy_after_arm", 32'(busy), 1);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(2, 32'(100 + i));
            trig = (i == 0);
            cyc();
            chk("m0_done_seq", 32'(done), (i == 4) ? 1 : 0);
        end
        trig = 1'b0;
        chk("m0_busy_end", 32'(busy), 0);
        chk("m0_stop_addr", 32'(stop_addr), 5);
        chk("m0_wrapped", 32'(wrapped), 0);
        din_valid = 1'b0;
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        chk("done_trig_ignored", 32'(done), 1);
        chk("done_stop_hold", 32'(stop_addr), 5);
        for (int i = 0; i < 5; i++) begin
            rd(i, 32'(100 + i));
            cyc();
        end
        rd_en = 1'b0;

        // gapped input, one valid in three cycles, three post samples on lane 1
        do_arm(1'b0, 1, 3);
        for (int c = 0; c < 7; c++) begin
            din_valid = ((c % 3) == 0);
            drive(1, 32'(200 + c / 3));
            trig = (c == 0);
            cyc();
            chk("gap_done_seq", 32'(done), (c == 6) ? 1 : 0);
        end
        trig = 1'b0;
        din_valid = 1'b0;
        chk("gap_stop_addr", 32'(stop_addr), 3);
        for (int i = 0; i < 3; i++) begin
            rd(i, 32'(200 + i));
            cyc();
        end
        rd_en = 1'b0;

        // arm and trig together: trigger dropped, sample not written
        din_valid = 1'b1;
        drive(0, 300);
        trig = 1'b1;
        do_arm(1'b0, 0, 2);
        trig = 1'b0;
        chk("armtrig_busy", 32'(busy), 1);
        drive(0, 301);
        cyc();
        chk("armtrig_not_post", 32'(done), 0);
        drive(0, 310);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        drive(0, 311);
        cyc();
        chk("armtrig_done", 32'(done), 1);
        chk("armtrig_stop_addr", 32'(stop_addr), 2);

        // post_count of zero: done straight from the trigger, nothing written
        drive(0, 400);
        do_arm(1'b0, 0, 0);
        chk("pc0_not_done", 32'(done), 0);
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        din_valid = 1'b0;
        chk("pc0_done", 32'(done), 1);
        chk("pc0_busy", 32'(busy), 0);
        chk("pc0_stop_addr", 32'(stop_addr), 0);
        rd(0, 310);
        cyc();
        rd(1, 311);
        cyc();
        rd_en = 1'b0;

        // circular: 20 pre samples, trigger, 4 post samples on lane 3 (values 1000+i)
        din_valid = 1'b1;
        drive(3, 0);
        do_arm(1'b1, 3, 4);
        for (int i = 0; i < 24; i++) begin
            drive(3, 32'(1000 + i));
            trig = (i == 20);
            cyc();
            if (i == 14) chk("m1_wrapped_before", 32'(wrapped), 0);
            if (i == 15) chk("m1_wrapped_after", 32'(wrapped), 1);
            if (i == 22) chk("m1_not_done", 32'(done), 0);
        end
        trig = 1'b0;
        din_valid = 1'b0;
        chk("m1_done", 32'(done), 1);
        chk("m1_wrapped", 32'(wrapped), 1);
        chk("m1_stop_addr", 32'(stop_addr), 8);
        for (int k = 0; k < 16; k++) begin
            rd((8 + k) % 16, 32'(1008 + k));
            cyc();
        end
        rd_en = 1'b0;
        cyc();

        // eight back-to-back reads at 0..7
        for (int a = 0; a < 8; a++) begin
            rd(a, 32'(1016 + a));
            cyc();
        end
        rd_en = 1'b0;
        cyc();

        // read-first on a same-cycle write to the same address
        drive(0, 0);
        do_arm(1'b1, 0, 16);
        din_valid = 1'b1;
        drive(0, 2000);
        rd(0, 1016);
        cyc();
        drive(0, 2001);
        rd(0, 2000);
        cyc();
        rd_en = 1'b0;
        din_valid = 1'b0;

        for (int i = 0; i < 50 && exp_dat_q.size() != 0; i++) cyc();
        repeat (3) cyc();
        chk("rd_drain", 32'(exp_dat_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
